// File: rtl/fsm_ctrl_param.sv
// fsm_ctrl_param
// Flow-control FSM for a bank of NUM_FIFOS FIFOs. It latches per-FIFO
// low/high thresholds during INIT and always emits them ordered as
// low <= high. It tracks global emptiness with a debounced idle
// detector, and it latches per-FIFO errors into a sticky capture
// register.
//
// Optional feature: define FSM_ERR_CLEAR_EN to add the err_clr input,
// which lets the FSM leave ERROR without a reset.
//
// Ports:
//   clk          system clock, all logic on posedge
//   reset        synchronous, active-low reset
//   init         request (re)load of thresholds
//   th_low_in    packed low thresholds, channel i at [i*TH_W +: TH_W]
//   th_high_in   packed high thresholds, same packing
//   empties      per-FIFO empty flags
//   errors       per-FIFO error flags
//   err_clr      (FSM_ERR_CLEAR_EN only) leave ERROR towards INIT
//   th_low_out   registered low thresholds (min of each input pair)
//   th_high_out  registered high thresholds (max of each input pair)
//   state        current state: RESET=0 INIT=1 IDLE=2 ACTIVE=3 ERROR=4
//   idle_out     state == IDLE
//   active_out   state == ACTIVE
//   error_out    state == ERROR
//   error_src    sticky per-FIFO error capture
module fsm_ctrl_param #(
    parameter int NUM_FIFOS   = 5,
    parameter int TH_W        = 5,
    parameter int IDLE_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      init,
    input  logic [NUM_FIFOS*TH_W-1:0] th_low_in,
    input  logic [NUM_FIFOS*TH_W-1:0] th_high_in,
    input  logic [NUM_FIFOS-1:0]      empties,
    input  logic [NUM_FIFOS-1:0]      errors,
`ifdef FSM_ERR_CLEAR_EN
    input  logic                      err_clr,
`endif
    output logic [NUM_FIFOS*TH_W-1:0] th_low_out,
    output logic [NUM_FIFOS*TH_W-1:0] th_high_out,
    output logic [2:0]                state,
    output logic                      idle_out,
    output logic                      active_out,
    output logic                      error_out,
    output logic [NUM_FIFOS-1:0]      error_src
);

    localparam logic [2:0] ST_RESET  = 3'd0;
    localparam logic [2:0] ST_INIT   = 3'd1;
    localparam logic [2:0] ST_IDLE   = 3'd2;
    localparam logic [2:0] ST_ACTIVE = 3'd3;
    localparam logic [2:0] ST_ERROR  = 3'd4;

    localparam int CNT_W = $clog2(IDLE_CYCLES + 1);
    // The counter value on the edge that completes the debounce.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_CYCLES - 1);

    logic [CNT_W-1:0]          cnt;
    logic [CNT_W-1:0]          cnt_next;
    logic [2:0]                state_next;
    logic [NUM_FIFOS-1:0]      src_next;
    logic [NUM_FIFOS*TH_W-1:0] th_lo_ld;
    logic [NUM_FIFOS*TH_W-1:0] th_hi_ld;
    logic                      all_empty;

    assign all_empty = &empties;

    // Order each input pair so that the low output never exceeds the high one.
    always_comb begin
        th_lo_ld = '0;
        th_hi_ld = '0;
        for (int i = 0; i < NUM_FIFOS; i++) begin
            if (th_low_in[i*TH_W +: TH_W] <= th_high_in[i*TH_W +: TH_W]) begin
                th_lo_ld[i*TH_W +: TH_W] = th_low_in[i*TH_W +: TH_W];
                th_hi_ld[i*TH_W +: TH_W] = th_high_in[i*TH_W +: TH_W];
            end else begin
                th_lo_ld[i*TH_W +: TH_W] = th_high_in[i*TH_W +: TH_W];
                th_hi_ld[i*TH_W +: TH_W] = th_low_in[i*TH_W +: TH_W];
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        src_next   = error_src;
        case (state)
            ST_RESET: state_next = ST_INIT;
            ST_ERROR: begin
                src_next = error_src | errors;
`ifdef FSM_ERR_CLEAR_EN
                // A clear with errors still present restarts the capture.
                if (err_clr) begin
                    if (|errors) begin
                        src_next = errors;
                    end else begin
                        src_next   = '0;
                        state_next = ST_INIT;
                    end
                end
`endif
            end
            default: begin
                if (|errors) begin
                    state_next = ST_ERROR;
                    src_next   = error_src | errors;
                end else if (init) begin
                    state_next = ST_INIT;
                end else begin
                    case (state)
                        ST_INIT: state_next = ST_IDLE;
                        ST_IDLE: begin
                            if (!all_empty) state_next = ST_ACTIVE;
                        end
                        ST_ACTIVE: begin
                            if (all_empty) begin
                                if (cnt == CNT_LAST) state_next = ST_IDLE;
                                else cnt_next = cnt + CNT_W'(1);
                            end else begin
                                cnt_next = '0;
                            end
                        end
                        default: state_next = ST_RESET;
                    endcase
                end
            end
        endcase
        // The debounce always starts from zero on entry into ACTIVE.
        if (state_next != ST_ACTIVE) cnt_next = '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_RESET;
            cnt         <= '0;
            error_src   <= '0;
            th_low_out  <= '0;
            th_high_out <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            error_src <= src_next;
            // INIT loads on every edge, including one that leaves for ERROR.
            if (state == ST_INIT) begin
                th_low_out  <= th_lo_ld;
                th_high_out <= th_hi_ld;
            end
        end
    end

    assign idle_out   = (state == ST_IDLE);
    assign active_out = (state == ST_ACTIVE);
    assign error_out  = (state == ST_ERROR);

endmodule

// File: tb/tb_fsm_ctrl_param.sv
module tb_fsm_ctrl_param;
    localparam int N  = 5;
    localparam int TW = 5;
    localparam int IC = 2;

    logic clk = 1'b0;
    logic reset, init;
    logic [N*TW-1:0] th_low_in, th_high_in, th_low_out, th_high_out;
    logic [N-1:0] empties, errors, error_src;
    logic [2:0] state;
    logic idle_out, active_out, error_out;
`ifdef FSM_ERR_CLEAR_EN
    logic err_clr;
`endif

    fsm_ctrl_param #(.NUM_FIFOS(N), .TH_W(TW), .IDLE_CYCLES(IC)) dut (
        .clk(clk), .reset(reset), .init(init),
        .th_low_in(th_low_in), .th_high_in(th_high_in),
        .empties(empties), .errors(errors),
`ifdef FSM_ERR_CLEAR_EN
        .err_clr(err_clr),
`endif
        .th_low_out(th_low_out), .th_high_out(th_high_out),
        .state(state), .idle_out(idle_out), .active_out(active_out),
        .error_out(error_out), .error_src(error_src)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;
    logic chk_en = 1'b0;

    // Reference model: mode numbers are the documented state codes.
    int m_mode = 0;
    int m_run = 0;
    logic [N*TW-1:0] m_low = '0, m_high = '0;
    logic [N-1:0] m_src = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(posedge clk) begin
        if (!reset) begin
            m_mode = 0; m_run = 0; m_low = '0; m_high = '0; m_src = '0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 4) begin
`ifdef FSM_ERR_CLEAR_EN
            if (err_clr) begin
                if (errors != 0) m_src = errors;
                else begin m_src = '0; m_mode = 1; end
            end else m_src = m_src | errors;
`else
            m_src = m_src | errors;
`endif
        end else begin
            if (m_mode == 1) begin
                for (int i = 0; i < N; i++) begin
                    int a, b;
                    a = th_low_in[i*TW +: TW];
                    b = th_high_in[i*TW +: TW];
                    m_low[i*TW +: TW]  = TW'((a < b) ? a : b);
                    m_high[i*TW +: TW] = TW'((a < b) ? b : a);
                end
            end
            if (errors != 0) begin
                m_mode = 4; m_src = m_src | errors; m_run = 0;
            end else if (init) begin
                m_mode = 1; m_run = 0;
            end else if (m_mode == 1) begin
                m_mode = 2;
            end else if (m_mode == 2) begin
                if (!(&empties)) begin m_mode = 3; m_run = 0; end
            end else if (m_mode == 3) begin
                if (&empties) begin
                    m_run++;
                    if (m_run == IC) begin m_mode = 2; m_run = 0; end
                end else m_run = 0;
            end
        end
    end

    // Compare process: every cycle once reset has been applied.
    always @(negedge clk) begin
        if (chk_en) begin
            check("state", 64'(state), 64'(m_mode));
            check("idle_out", 64'(idle_out), 64'(m_mode == 2));
            check("active_out", 64'(active_out), 64'(m_mode == 3));
            check("error_out", 64'(error_out), 64'(m_mode == 4));
            check("th_low_out", 64'(th_low_out), 64'(m_low));
            check("th_high_out", 64'(th_high_out), 64'(m_high));
            check("error_src", 64'(error_src), 64'(m_src));
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; init = 1'b0; empties = '0; errors = '0;
        th_low_in = '0; th_high_in = '0;
`ifdef FSM_ERR_CLEAR_EN
        err_clr = 1'b0;
`endif
        @(negedge clk);
        tick();
        chk_en = 1'b1;
        check("lit_reset_state", 64'(state), 64'd0);
        check("lit_reset_th", 64'({th_low_out, th_high_out}), 64'd0);
        check("lit_reset_src", 64'(error_src), 64'd0);

        reset = 1'b1;
        tick(); check("lit_to_init", 64'(state), 64'd1);
        tick(); check("lit_to_idle", 64'(state), 64'd2);
        tick(); check("lit_to_active", 64'(state), 64'd3);

        // Threshold load with a swapped pair on channel 1.
        th_low_in[4:0] = 5'd3;  th_high_in[4:0] = 5'd9;
        th_low_in[9:5] = 5'd20; th_high_in[9:5] = 5'd4;
        init = 1'b1;
        tick(); check("lit_reinit", 64'(state), 64'd1);
        init = 1'b0;
        tick();
        check("lit_ch0_low", 64'(th_low_out[4:0]), 64'd3);
        check("lit_ch0_high", 64'(th_high_out[4:0]), 64'd9);
        check("lit_ch1_low", 64'(th_low_out[9:5]), 64'd4);
        check("lit_ch1_high", 64'(th_high_out[9:5]), 64'd20);
        check("lit_model_ch1_low", 64'(m_low[9:5]), 64'd4);
        th_low_in = '1; th_high_in = '0;
        tick(); check("lit_active2", 64'(state), 64'd3);
        check("lit_held_ch1_high", 64'(th_high_out[9:5]), 64'd20);

        // Idle debounce.
        empties = 5'b11111; tick(); check("lit_deb1", 64'(state), 64'd3);
        empties = 5'b11110; tick(); check("lit_deb2", 64'(state), 64'd3);
        empties = 5'b11111; tick(); check("lit_deb3", 64'(state), 64'd3);
        tick(); check("lit_deb_idle", 64'(idle_out), 64'd1);
        empties = 5'b00000; tick(); check("lit_back_active", 64'(state), 64'd3);

        // Error capture; init is ignored in ERROR.
        errors = 5'b00100; tick(); check("lit_err_state", 64'(state), 64'd4);
        errors = 5'b01000; init = 1'b1; tick();
        check("lit_err_out", 64'(error_out), 64'd1);
        check("lit_err_src", 64'(error_src), 64'h0c);
        check("lit_model_src", 64'(m_src), 64'h0c);
        errors = '0; tick(); check("lit_err_sticky", 64'(state), 64'd4);
        init = 1'b0;

`ifdef FSM_ERR_CLEAR_EN
        err_clr = 1'b1; tick();
        check("lit_clr_init", 64'(state), 64'd1);
        check("lit_clr_src", 64'(error_src), 64'd0);
        err_clr = 1'b0; errors = 5'b00010; tick();
        check("lit_err_again", 64'(state), 64'd4);
        errors = 5'b00001; err_clr = 1'b1; tick();
        check("lit_clr_stay", 64'(state), 64'd4);
        check("lit_clr_src2", 64'(error_src), 64'd1);
        err_clr = 1'b0; errors = '0;
`endif

        // Reset mid-operation.
        reset = 1'b0; tick();
        check("lit_mid_state", 64'(state), 64'd0);
        check("lit_mid_src", 64'(error_src), 64'd0);
        check("lit_mid_th", 64'({th_low_out, th_high_out}), 64'd0);
        check("lit_mid_flags", 64'({idle_out, active_out, error_out}), 64'd0);
        reset = 1'b1;

        // Randomized phase against the model.
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 99) != 0);
            init = ($urandom_range(0, 11) == 0);
            errors = ($urandom_range(0, 59) == 0) ? N'(1 << $urandom_range(0, N-1)) : '0;
            empties = ($urandom_range(0, 2) != 0) ? '1 : N'($urandom);
            th_low_in = (N*TW)'({$urandom, $urandom});
            th_high_in = (N*TW)'({$urandom, $urandom});
`ifdef FSM_ERR_CLEAR_EN
            err_clr = ($urandom_range(0, 7) == 0);
`endif
            tick();
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
